pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register (D->E, E->M, M->W) for the 5-stage MIPS core.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_reg.sv | 119 +++++++++++
 tb/tb_pipe_stage_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_TNEW_W = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Payload channel indices as used by the D->E register.
  localparam int unsigned CH_RS  = 0;
  localparam int unsigned CH_RT  = 1;
  localparam int unsigned CH_IMM = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall (hold), flush (bubble),
// Tnew countdown and a saturating consecutive-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W           = DEFAULT_DATA_W,
  parameter int unsigned       NUM_CH           = 3,
  parameter int unsigned       TNEW_W           = DEFAULT_TNEW_W,
  parameter int unsigned       STALL_CNT_W      = 8,
  parameter logic [DATA_W-1:0] RESET_PC         = '0,
  parameter bit                KEEP_PC_ON_FLUSH = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_instr,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [NUM_CH*DATA_W-1:0] in_ch,
  input  logic [TNEW_W-1:0]        in_tnew,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instr,
  output logic [DATA_W-1:0]        out_pc,
  output logic [NUM_CH*DATA_W-1:0] out_ch,
  output logic [TNEW_W-1:0]        out_tnew,
  output logic [STALL_CNT_W-1:0]   out_stall_cnt
);

  localparam int unsigned CH_W = NUM_CH * DATA_W;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  logic                   valid_d, valid_q;
  logic [DATA_W-1:0]      instr_d, instr_q;
  logic [DATA_W-1:0]      pc_d, pc_q;
  logic [CH_W-1:0]        ch_d, ch_q;
  logic [TNEW_W-1:0]      tnew_d, tnew_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  // A flushed slot and an invalid upstream slot both carry a bubble payload.
  logic bubble;
  always_comb begin
    bubble = flush || !in_valid;
  end

  always_comb begin
    valid_d = valid_q;
    if (!stall) valid_d = flush ? 1'b0 : in_valid;
  end

  always_comb begin
    instr_d = instr_q;
    if (!stall) instr_d = bubble ? DATA_W'(NOP_INSTR) : in_instr;
  end

  // pc follows upstream even for bubbles so exceptions can locate the slot.
  always_comb begin
    pc_d = pc_q;
    if (!stall) pc_d = (flush && !KEEP_PC_ON_FLUSH) ? '0 : in_pc;
  end

  always_comb begin
    ch_d = ch_q;
    if (!stall) ch_d = bubble ? '0 : in_ch;
  end

  always_comb begin
    tnew_d = tnew_q;
    if (!stall) tnew_d = bubble ? '0 : sat_dec(in_tnew);
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) instr_q <= '0;
    else       instr_q <= instr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) ch_q <= '0;
    else       ch_q <= ch_d;
  end

  always_ff @(posedge clk) begin
    if (reset) tnew_q <= '0;
    else       tnew_q <= tnew_d;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign out_valid     = valid_q;
  assign out_instr     = instr_q;
  assign out_pc        = pc_q;
  assign out_ch        = ch_q;
  assign out_tnew      = tnew_q;
  assign out_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: three instances (default, no-pc-keep,
// 2-bit stall counter) share stimulus and are checked against a behavioural model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [95:0] ch;
    logic [1:0]  tnew;
    logic [7:0]  cnt;
  } st_t;

  localparam logic [31:0] RPC_A = 32'hBFC0_0000;
  localparam logic [31:0] RPC_B = 32'h0000_0000;
  localparam logic [31:0] RPC_C = 32'h0000_3000;

  logic        clk;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_instr, in_pc;
  logic [95:0] in_ch;
  logic [1:0]  in_tnew;

  logic        a_valid, b_valid, c_valid;
  logic [31:0] a_instr, b_instr, c_instr, a_pc, b_pc, c_pc;
  logic [95:0] a_ch, b_ch, c_ch;
  logic [1:0]  a_tnew, b_tnew, c_tnew;
  logic [7:0]  a_cnt, b_cnt;
  logic [1:0]  c_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  st_t mdl_a, mdl_b, mdl_c;
  st_t q_a[$], q_b[$], q_c[$];

  pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .TNEW_W(2), .STALL_CNT_W(8),
                   .RESET_PC(RPC_A), .KEEP_PC_ON_FLUSH(1'b1)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_ch(in_ch), .in_tnew(in_tnew),
    .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc), .out_ch(a_ch),
    .out_tnew(a_tnew), .out_stall_cnt(a_cnt));

  pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .TNEW_W(2), .STALL_CNT_W(8),
                   .RESET_PC(RPC_B), .KEEP_PC_ON_FLUSH(1'b0)) u_nokeep (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_ch(in_ch), .in_tnew(in_tnew),
    .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc), .out_ch(b_ch),
    .out_tnew(b_tnew), .out_stall_cnt(b_cnt));

  pipe_stage_reg #(.DATA_W(32), .NUM_CH(3), .TNEW_W(2), .STALL_CNT_W(2),
                   .RESET_PC(RPC_C), .KEEP_PC_ON_FLUSH(1'b1)) u_sc2 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_pc(in_pc), .in_ch(in_ch), .in_tnew(in_tnew),
    .out_valid(c_valid), .out_instr(c_instr), .out_pc(c_pc), .out_ch(c_ch),
    .out_tnew(c_tnew), .out_stall_cnt(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next-state of one register instance given the current bench inputs.
  function automatic st_t step(input st_t s, input bit keep, input logic [7:0] cmax,
                               input logic [31:0] rpc);
    st_t n = s;
    if (reset) begin
      n    = '0;
      n.pc = rpc;
    end else if (stall) begin
      if (s.cnt != cmax) n.cnt = s.cnt + 8'd1;
    end else begin
      n.cnt = 8'd0;
      if (flush) begin
        n.v = 1'b0; n.instr = 32'd0; n.ch = 96'd0; n.tnew = 2'd0;
        n.pc = keep ? in_pc : 32'd0;
      end else begin
        n.v  = in_valid;
        n.pc = in_pc;
        if (in_valid) begin
          n.instr = in_instr;
          n.ch    = in_ch;
          n.tnew  = (in_tnew == 2'd0) ? 2'd0 : in_tnew - 2'd1;
        end else begin
          n.instr = 32'd0; n.ch = 96'd0; n.tnew = 2'd0;
        end
      end
    end
    return n;
  endfunction

  task automatic cmp_state(input string name, input st_t e, input st_t g);
    check_eq({name, ".valid"}, 128'(g.v), 128'(e.v));
    check_eq({name, ".instr"}, 128'(g.instr), 128'(e.instr));
    check_eq({name, ".pc"}, 128'(g.pc), 128'(e.pc));
    check_eq({name, ".ch"}, 128'(g.ch), 128'(e.ch));
    check_eq({name, ".tnew"}, 128'(g.tnew), 128'(e.tnew));
    check_eq({name, ".stall_cnt"}, 128'(g.cnt), 128'(e.cnt));
  endtask

  // Push expectations for the current inputs, clock once, then score all instances.
  task automatic tick();
    st_t ga, gb, gc;
    mdl_a = step(mdl_a, 1'b1, 8'd255, RPC_A); q_a.push_back(mdl_a);
    mdl_b = step(mdl_b, 1'b0, 8'd255, RPC_B); q_b.push_back(mdl_b);
    mdl_c = step(mdl_c, 1'b1, 8'd3,   RPC_C); q_c.push_back(mdl_c);
    @(posedge clk);
    #1;
    ga = '{v: a_valid, instr: a_instr, pc: a_pc, ch: a_ch, tnew: a_tnew, cnt: a_cnt};
    gb = '{v: b_valid, instr: b_instr, pc: b_pc, ch: b_ch, tnew: b_tnew, cnt: b_cnt};
    gc = '{v: c_valid, instr: c_instr, pc: c_pc, ch: c_ch, tnew: c_tnew, cnt: {6'd0, c_cnt}};
    check_eq("sb.depth", 128'(q_a.size() + q_b.size() + q_c.size()), 128'd3);
    if (q_a.size() > 0) cmp_state("dut", q_a.pop_front(), ga);
    if (q_b.size() > 0) cmp_state("nokeep", q_b.pop_front(), gb);
    if (q_c.size() > 0) cmp_state("sc2", q_c.pop_front(), gc);
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic [95:0] ch, input logic [1:0] tn);
    reset = r; stall = s; flush = f; in_valid = v;
    in_instr = instr; in_pc = pc; in_ch = ch; in_tnew = tn;
  endtask

  initial begin
    mdl_a = '0; mdl_b = '0; mdl_c = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, {3{32'hA5A5_A5A5}}, 2'd3);
    #2;
    // Reset with busy inputs
    tick(); tick();

    // Plain load
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h3004, {32'd3, 32'd2, 32'd1}, 2'd2);
    tick();

    // Stall three cycles while inputs move, then load
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'h4000 + 32'(4*i),
            {3{32'h5555_0000 + 32'(i)}}, 2'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0234_5678, 32'h3008, {32'd9, 32'd8, 32'd7}, 2'd3);
    tick();

    // Flush
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3008, {3{32'hFFFF_FFFF}}, 2'd3);
    tick();

    // Load, then stall+flush together, then tnew=0 load and invalid load
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0021, 32'h300C, {32'd6, 32'd5, 32'd4}, 2'd1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0022, 32'h3010, {3{32'd0}}, 2'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0023, 32'h3014, {32'd1, 32'd1, 32'd1}, 2'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0024, 32'h3018, {32'd2, 32'd2, 32'd2}, 2'd3);
    tick();

    // Five-cycle stall saturates the 2-bit counter, reset mid-stall, resume
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0025, 32'h301C, {32'd3, 32'd3, 32'd3}, 2'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h7000 + 32'(i), 32'h5000, {3{32'(i)}}, 2'd1);
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0026, 32'h3020, {3{32'hCAFE}}, 2'd2);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0027, 32'h3024, {32'd4, 32'd4, 32'd4}, 2'd2);
    tick();

    // Long stall saturates the 8-bit counter
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom, {$urandom, $urandom, $urandom},
            2'($urandom_range(0, 3)));
      tick();
    end

    // Random mix of controls
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, $urandom, $urandom, {$urandom, $urandom, $urandom},
            2'($urandom_range(0, 3)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
